// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared definitions for the multi-cycle HI/LO unit.
//   - MD_WIDTH   : default operand / HI / LO width
//   - md_op_e    : op_code encodings (MD_MULT..MD_MTLO; 6,7 reserved)
//   - md_state_e : sequencer states
package muldiv_sequencer_pkg;

   localparam int unsigned MD_WIDTH = 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand latch, 2*WIDTH accumulator, radix-2 shift-add
// multiply step, restoring divide step and final sign correction.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   load_i           latch operand magnitudes and signs (start of operation)
//   is_div_i         operation being loaded is a divide
//   signed_i         operation being loaded is signed
//   step_i           perform one multiply or divide iteration
//   a_i, b_i         rs / rt operands
//   res_hi_o/res_lo_o sign-corrected result (HI=remainder, LO=quotient for divide)
module muldiv_datapath
   import muldiv_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load_i,
   input  logic             is_div_i,
   input  logic             signed_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_hi_o,
   output logic [WIDTH-1:0] res_lo_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor
   logic [WIDTH-1:0]   mplr_q, mplr_d;   // multiplier, consumed LSB first
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic               is_div_q, is_div_d;

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_rem, div_diff;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      abs_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
      abs_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

      // Carry out of the upper-half add becomes the new MSB after the shift.
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplr_q[0] ? opb_q : '0)};
      // Partial remainder after the left shift needs one extra bit.
      div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_rem - {1'b0, opb_q};

      acc_d     = acc_q;
      opb_d     = opb_q;
      mplr_d    = mplr_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      is_div_d  = is_div_q;

      if (load_i) begin
         neg_d     = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
         neg_rem_d = signed_i & a_i[WIDTH-1];
         is_div_d  = is_div_i;
         if (is_div_i) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opb_d  = abs_b;
            mplr_d = '0;
         end else begin
            acc_d  = '0;
            opb_d  = abs_a;
            mplr_d = abs_b;
         end
      end else if (step_i) begin
         if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
            mplr_d = mplr_q >> 1;
         end
      end
   end

   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      if (is_div_q) begin
         res_lo_o = neg_q     ? -acc_q[WIDTH-1:0]         : acc_q[WIDTH-1:0];
         res_hi_o = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]   : acc_q[2*WIDTH-1:WIDTH];
      end else begin
         res_lo_o = prod[WIDTH-1:0];
         res_hi_o = prod[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         acc_q     <= '0;
         opb_q     <= '0;
         mplr_q    <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         mplr_q    <= mplr_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         is_div_q  <= is_div_d;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
// with MFHI/MFLO stall. Optional sticky divide-by-zero flag under
// `define MULDIV_DIV0_FLAG_EN (otherwise div0 is tied low).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   op_valid/op_code    command handshake (accepted when op_valid && op_ready)
//   rs_data/rt_data     operands
//   op_ready, busy      !busy / operation in flight
//   done                one-cycle pulse when HI/LO hold a new result
//   rd_req/rd_sel       MFHI/MFLO request, 0=LO 1=HI
//   rd_data, stall      combinational read data, read stall
//   div0                sticky divide-by-zero flag
//   hi, lo              HI/LO registers
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             op_valid,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             op_ready,
   output logic             busy,
   output logic             done,
   input  logic             rd_req,
   input  logic             rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             stall,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;

   logic             dp_load, dp_div, dp_signed, dp_step;
   logic [WIDTH-1:0] res_hi, res_lo;

   muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .CLK      (CLK),
      .RST      (RST),
      .load_i   (dp_load),
      .is_div_i (dp_div),
      .signed_i (dp_signed),
      .step_i   (dp_step),
      .a_i      (rs_data),
      .b_i      (rt_data),
      .res_hi_o (res_hi),
      .res_lo_o (res_lo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dp_load   = 1'b0;
      dp_div    = 1'b0;
      dp_signed = 1'b0;
      dp_step   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               case (op_code)
                  MD_MULT, MD_MULTU: begin
                     dp_load   = 1'b1;
                     dp_signed = (op_code == MD_MULT);
                     state_d   = ST_MUL;
                  end
                  MD_DIV, MD_DIVU: begin
                     // Divide by zero completes immediately without touching HI/LO.
                     if (rt_data == '0) begin
                        done_d = 1'b1;
                     end else begin
                        dp_load   = 1'b1;
                        dp_div    = 1'b1;
                        dp_signed = (op_code == MD_DIV);
                        state_d   = ST_DIV;
                     end
                  end
                  MD_MTHI: hi_d = rs_data;
                  MD_MTLO: lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            dp_step = 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FIX: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

`ifdef MULDIV_DIV0_FLAG_EN
   logic div0_q;
   // In IDLE, done_d is only raised by a divide-by-zero accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         div0_q <= 1'b0;
      end else if (state_q == ST_IDLE && done_d) begin
         div0_q <= 1'b1;
      end
   end
   assign div0 = div0_q;
`else
   assign div0 = 1'b0;
`endif

   assign busy     = (state_q != ST_IDLE);
   assign op_ready = ~busy;
   assign done     = done_q;
   assign stall    = rd_req & busy;
   assign rd_data  = rd_sel ? hi_q : lo_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer.
// Honours MULDIV_DIV0_FLAG_EN when choosing the expected div0 value.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = '0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        op_ready, busy, done, stall, div0;
   logic        rd_req = 1'b0;
   logic        rd_sel = 1'b0;
   logic [31:0] rd_data, hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .op_valid (op_valid),
      .op_code  (op_code),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .op_ready (op_ready),
      .busy     (busy),
      .done     (done),
      .rd_req   (rd_req),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data),
      .stall    (stall),
      .div0     (div0),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command and wait (bounded) for done; lat counts cycles from
   // the accept edge to the done cycle, bcnt counts busy cycles seen.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output int bcnt);
      @(negedge CLK);
      op_valid = 1'b1; op_code = op; rs_data = a; rt_data = b;
      @(negedge CLK);
      op_valid = 1'b0;
      lat  = 1;
      bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(negedge CLK);
         lat++;
      end
      check({tag, "_done"}, done, 1);
   endtask

   task automatic md_test(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat, bcnt;
      run_op(tag, op, a, b, lat, bcnt);
      check({tag, "_lat"},   lat, 34);
      check({tag, "_busy"},  bcnt, 33);
      check({tag, "_ready"}, op_ready, 1);
      check({tag, "_hi"},    hi, exp_hi);
      check({tag, "_lo"},    lo, exp_lo);
      @(negedge CLK);
      check({tag, "_done1"}, done, 0);
   endtask

   task automatic mt_write(input logic [2:0] op, input logic [31:0] v);
      @(negedge CLK);
      op_valid = 1'b1; op_code = op; rs_data = v;
      @(negedge CLK);
      op_valid = 1'b0;
   endtask

   initial begin
      int lat, bcnt, cyc, st_cnt, rdy_cnt, dn_cnt;

      repeat (2) @(negedge CLK);
      check("rst_hi",    hi, 0);
      check("rst_lo",    lo, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_div0",  div0, 0);
      check("rst_ready", op_ready, 1);
      RST = 1'b0;

      md_test("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
      md_test("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      md_test("mult_ext",  MD_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
      md_test("divu",      MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
      md_test("div_nn",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      md_test("div_pn",    MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
      md_test("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);

      // Move-to writes, visible on rd_data the following cycle.
      mt_write(MD_MTHI, 32'h1234);
      rd_sel = 1'b1; #1;
      check("mthi_rd", rd_data, 32'h1234);
      check("mthi_busy", busy, 0);
      mt_write(MD_MTLO, 32'h5678);
      rd_sel = 1'b0; #1;
      check("mtlo_rd", rd_data, 32'h5678);

      // Divide by zero: immediate done, no busy, HI/LO untouched.
      run_op("div0", MD_DIV, 32'd5, 32'd0, lat, bcnt);
      check("div0_lat",  lat, 1);
      check("div0_busy", bcnt, 0);
      check("div0_hi",   hi, 32'h1234);
      check("div0_lo",   lo, 32'h5678);
`ifdef MULDIV_DIV0_FLAG_EN
      check("div0_flag", div0, 1);
`else
      check("div0_flag", div0, 0);
`endif
      @(negedge CLK);
      check("div0_done1", done, 0);

      // Reserved op code has no effect.
      mt_write(3'd6, 32'hDEAD);
      check("rsv_busy", busy, 0);
      check("rsv_hi",   hi, 32'h1234);
      check("rsv_lo",   lo, 32'h5678);

      // Read stall during a multiply; a held MTHI is accepted as busy drops.
      @(negedge CLK);
      op_valid = 1'b1; op_code = MD_MULTU; rs_data = 32'd7; rt_data = 32'd6;
      rd_req = 1'b1; rd_sel = 1'b0;
      @(negedge CLK);
      op_code = MD_MTHI; rs_data = 32'hBEEF;
      cyc = 1; st_cnt = 0; rdy_cnt = 0;
      while (!done && cyc < 100) begin
         if (stall) st_cnt++;
         if (op_ready) rdy_cnt++;
         @(negedge CLK);
         cyc++;
      end
      check("stl_done",   done, 1);
      check("stl_cnt",    st_cnt, 33);
      check("stl_ready",  rdy_cnt, 0);
      check("stl_end",    stall, 0);
      check("stl_rd",     rd_data, 32'd42);
      check("stl_hi",     hi, 32'd0);
      @(negedge CLK);
      op_valid = 1'b0; rd_req = 1'b0;
      check("held_hi",    hi, 32'hBEEF);
      check("held_lo",    lo, 32'd42);
      check("held_busy",  busy, 0);

      // Reset in the middle of a divide.
      @(negedge CLK);
      op_valid = 1'b1; op_code = MD_DIVU; rs_data = 32'd100; rt_data = 32'd7;
      @(negedge CLK);
      op_valid = 1'b0;
      repeat (9) @(negedge CLK);
      check("mid_busy", busy, 1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_hi",   hi, 0);
      check("abort_lo",   lo, 0);
      check("abort_done", done, 0);
      dn_cnt = 0; bcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (done) dn_cnt++;
         if (busy) bcnt++;
      end
      check("abort_nodone", dn_cnt, 0);
      check("abort_nobusy", bcnt, 0);
      check("abort_lo2",    lo, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
